bp_me_cce_mem_arbiter: RTL and testbench
========================================

BP_ME_CCE_MEM_ARBITER -- requirements
Module: bp_me_cce_mem_arbiter

Interface
REQ-001 Parameter num_req_p, default 2: number of CCE mem_cmd requesters (2..8).
REQ-002 Parameter msg_width_p, default 128: width of one bp_cce_mem_msg_s (header plus data).
REQ-003 Parameter tag_els_p, default 4: depth of the requester-ID tag FIFO (power of 2).
REQ-004 Parameter max_out_p, default 2: per-requester outstanding-command limit (credit build only).
REQ-005 clk_i  in  1  clock; single clock domain.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 mem_cmd_i  in  num_req_p*msg_width_p  requester commands; requester k occupies slice k.
REQ-008 mem_cmd_v_i  in  num_req_p  per-requester command valid.
REQ-009 mem_cmd_ready_o  out  num_req_p  per-requester command ready (ready&valid).
REQ-010 mem_cmd_o  out  msg_width_p  granted command toward memory.
REQ-011 mem_cmd_v_o  out  1  command valid toward memory.
REQ-012 mem_cmd_ready_i  in  1  memory ready.
REQ-013 mem_resp_i  in  msg_width_p  memory response.
REQ-014 mem_resp_v_i  in  1  memory response valid.
REQ-015 mem_resp_yumi_o  out  1  memory response consumed (valid->yumi).
REQ-016 mem_resp_o  out  msg_width_p  response broadcast to all requesters (equal to mem_resp_i).
REQ-017 mem_resp_v_o  out  num_req_p  one-hot response valid to the owning requester.
REQ-018 mem_resp_yumi_i  in  num_req_p  per-requester response yumi.
REQ-019 err_o  out  1  sticky protocol error flag.

Function
REQ-020 Every accepted mem_cmd produces exactly one mem_resp; memory returns responses in command order.
REQ-021 Requester k is eligible when mem_cmd_v_i[k]=1, the tag FIFO is not full, and (credit build only) credit[k]<max_out_p.
REQ-022 Two-state FSM: e_idle, e_locked.
REQ-023 e_idle: round-robin selection among eligible requesters, starting at rr_ptr; if any is eligible, drive mem_cmd_v_o=1 and mem_cmd_o=slice[g] in the same cycle.
REQ-024 e_idle: handshake in the same cycle leaves the FSM in e_idle; no handshake latches g and moves the FSM to e_locked.
REQ-025 e_locked: grant fixed at the latched g; mem_cmd_v_o=1 and mem_cmd_o tracks slice[g] until handshake, then return to e_idle.
REQ-026 mem_cmd_v_o never depends combinationally on mem_cmd_ready_i.
REQ-027 mem_cmd_ready_o[g]=mem_cmd_ready_i & mem_cmd_v_o for the granted g; all other bits are 0.
REQ-028 On each command handshake: rr_ptr <= (g+1) mod num_req_p, and g is enqueued into the tag FIFO.
REQ-029 Tag FIFO full blocks new grants even if a dequeue occurs in the same cycle; a locked grant still completes.
REQ-030 Response routing: when mem_resp_v_i=1 and the FIFO is non-empty, mem_resp_v_o[head]=1 and mem_resp_yumi_o=mem_resp_yumi_i[head]; yumi on a tag dequeues the head.
REQ-031 mem_resp_v_i=1 with an empty FIFO: no mem_resp_v_o bit set, mem_resp_yumi_o=0, err_o set to 1 the next cycle and held.
REQ-032 mem_resp_yumi_i on a non-owning bit is ignored and sets err_o.
REQ-033 Zero-latency path: command issue and response delivery are combinational; only the FSM, rr_ptr, FIFO, credits and err_o are registered.
REQ-034 Combined-width vectors are LSB-first by requester index.

Reset
REQ-035 On reset_i=1 at a clk_i edge: FSM=e_idle, rr_ptr=0, tag FIFO empty, all credits=0, err_o=0.
REQ-036 During reset all of mem_cmd_v_o, mem_cmd_ready_o, mem_resp_v_o and mem_resp_yumi_o are 0.
REQ-037 Reset mid-transaction discards locked grants and tags; responses arriving afterward follow REQ-031.

Configuration
REQ-038 Macro BP_ME_MEM_ARB_CREDIT_EN defined: a per-requester counter of width clog2(max_out_p+1) exists.
REQ-039 Credit counter update rule: increment on that requester's command handshake, decrement on its response yumi; both in the same cycle leave it unchanged.
REQ-040 Macro BP_ME_MEM_ARB_CREDIT_EN undefined: no credit counters exist; eligibility is valid & FIFO not full only.

Verification
REQ-041 Both requesters hold valid, ready_i=1 continuously, responses returned immediately -> grants alternate 0,1,0,1; mem_resp_v_o alternates 01,10.
REQ-042 Requester 1 valid, ready_i=0 for 3 cycles, requester 0 raises valid in cycle 2 -> mem_cmd_o stays slice 1 until ready_i=1; requester 0 is granted next.
REQ-043 Requester 0 sends 4 commands, no responses, tag_els_p=4 -> fifth command is not granted until one response is yumi'd.
REQ-044 Credit build, max_out_p=2, requester 0 issues 3 back-to-back commands -> third is held until the first response yumi, while requester 1 is still granted.
REQ-045 mem_resp_v_i=1 after reset with no commands issued -> mem_resp_yumi_o=0, mem_resp_v_o=0, err_o=1 the next cycle and stays 1.
REQ-046 Reset asserted while in e_locked with 2 tags queued -> next cycle: mem_cmd_v_o=0, FIFO empty, rr_ptr=0.

Source files
------------

// File: rtl/bp_me_cce_mem_arbiter.sv
// Round-robin mem_cmd arbiter for N CCEs with an in-order tag FIFO that
// routes each memory response back to the requester that issued it.
// Ports: clk_i, reset_i (sync, active-high); mem_cmd_i/_v_i/_ready_o (per
// requester, LSB-first slices); mem_cmd_o/_v_o/_ready_i (to memory);
// mem_resp_i/_v_i/_yumi_o (from memory); mem_resp_o/_v_o/_yumi_i (to
// requesters); err_o sticky protocol error.
// Optional: BP_ME_MEM_ARB_CREDIT_EN adds per-requester outstanding credits.
module bp_me_cce_mem_arbiter #(
  parameter int num_req_p   = 2,
  parameter int msg_width_p = 128,
  parameter int tag_els_p   = 4,
  parameter int max_out_p   = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] mem_cmd_i,
  input  logic [num_req_p-1:0]             mem_cmd_v_i,
  output logic [num_req_p-1:0]             mem_cmd_ready_o,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,
  output logic [msg_width_p-1:0]           mem_resp_o,
  output logic [num_req_p-1:0]             mem_resp_v_o,
  input  logic [num_req_p-1:0]             mem_resp_yumi_i,
  output logic                             err_o
);

  localparam int lg_req_lp = $clog2(num_req_p);
  localparam int lg_tag_lp = $clog2(tag_els_p);
  localparam int cnt_w_lp  = $clog2(tag_els_p + 1);

  typedef enum logic {e_idle, e_locked} state_e;

  state_e               state_q;
  logic [lg_req_lp-1:0] gnt_q;
  logic [lg_req_lp-1:0] rr_ptr_q;
  logic [lg_req_lp-1:0] sel;
  logic [lg_req_lp-1:0] gnt;
  logic [lg_req_lp-1:0] rr_nxt;
  logic [lg_req_lp-1:0] head;
  logic [num_req_p-1:0] elig;
  logic                 any_elig;
  logic                 cmd_hs;
  logic                 resp_act;
  logic                 resp_yumi;
  logic                 err_set;

  logic [lg_req_lp-1:0] tag_mem [tag_els_p];
  logic [lg_tag_lp-1:0] wptr_q;
  logic [lg_tag_lp-1:0] rptr_q;
  logic [cnt_w_lp-1:0]  cnt_q;
  logic                 full;
  logic                 empty;

  logic [msg_width_p-1:0] cmd_arr [num_req_p];

  for (genvar k = 0; k < num_req_p; k++) begin : g_slice
    assign cmd_arr[k] = mem_cmd_i[k*msg_width_p +: msg_width_p];
  end

  assign full  = (cnt_q == cnt_w_lp'(tag_els_p));
  assign empty = (cnt_q == '0);
  assign head  = tag_mem[rptr_q];

`ifdef BP_ME_MEM_ARB_CREDIT_EN
  localparam int cr_w_lp = $clog2(max_out_p + 1);

  logic [cr_w_lp-1:0] credit_q [num_req_p];

  always_comb begin
    elig = '0;
    for (int k = 0; k < num_req_p; k++) begin
      elig[k] = mem_cmd_v_i[k] & ~full
              & (credit_q[k] < cr_w_lp'(max_out_p));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < num_req_p; k++) begin
      if (reset_i) begin
        credit_q[k] <= '0;
      end else begin
        unique case ({cmd_hs & (gnt == lg_req_lp'(k)),
                      resp_yumi & (head == lg_req_lp'(k))})
          2'b10:   credit_q[k] <= credit_q[k] + cr_w_lp'(1);
          2'b01:   credit_q[k] <= credit_q[k] - cr_w_lp'(1);
          default: credit_q[k] <= credit_q[k];
        endcase
      end
    end
  end
`else
  assign elig = mem_cmd_v_i & {num_req_p{~full}};
`endif

  // Rotate eligibility so bit i is requester (rr_ptr + i) mod N; the
  // lowest set bit wins, scanned high-to-low so the last write sticks.
  logic [2*num_req_p-1:0] rot;
  logic [lg_req_lp:0]     sum;

  always_comb begin
    rot      = {elig, elig} >> rr_ptr_q;
    sel      = rr_ptr_q;
    any_elig = 1'b0;
    sum      = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, rr_ptr_q} + (lg_req_lp+1)'(i);
        if (sum >= (lg_req_lp+1)'(num_req_p)) begin
          sum = sum - (lg_req_lp+1)'(num_req_p);
        end
        sel      = sum[lg_req_lp-1:0];
        any_elig = 1'b1;
      end
    end
  end

  assign gnt = (state_q == e_locked) ? gnt_q : sel;

  assign mem_cmd_v_o = ~reset_i & ((state_q == e_locked) | any_elig);
  assign cmd_hs      = mem_cmd_v_o & mem_cmd_ready_i;
  assign mem_cmd_o   = cmd_arr[gnt];

  always_comb begin
    mem_cmd_ready_o      = '0;
    mem_cmd_ready_o[gnt] = cmd_hs;
  end

  assign rr_nxt = (gnt == lg_req_lp'(num_req_p - 1))
                ? '0 : gnt + lg_req_lp'(1);

  assign resp_act   = ~reset_i & mem_resp_v_i & ~empty;
  assign resp_yumi  = resp_act & mem_resp_yumi_i[head];
  assign mem_resp_o = mem_resp_i;

  always_comb begin
    mem_resp_v_o       = '0;
    mem_resp_v_o[head] = resp_act;
  end

  assign mem_resp_yumi_o = resp_yumi;

  assign err_set = (mem_resp_v_i & empty)
                 | (|(mem_resp_yumi_i & ~mem_resp_v_o));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      err_o    <= 1'b0;
    end else begin
      unique case (state_q)
        e_idle: begin
          if (any_elig & ~mem_cmd_ready_i) begin
            state_q <= e_locked;
            gnt_q   <= sel;
          end
        end
        e_locked: begin
          if (mem_cmd_ready_i) state_q <= e_idle;
        end
        default: state_q <= e_idle;
      endcase

      if (cmd_hs) begin
        rr_ptr_q <= rr_nxt;
        wptr_q   <= wptr_q + lg_tag_lp'(1);
      end
      if (resp_yumi) rptr_q <= rptr_q + lg_tag_lp'(1);

      unique case ({cmd_hs, resp_yumi})
        2'b10:   cnt_q <= cnt_q + cnt_w_lp'(1);
        2'b01:   cnt_q <= cnt_q - cnt_w_lp'(1);
        default: cnt_q <= cnt_q;
      endcase

      err_o <= err_o | err_set;
    end
  end

  // Tag storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (cmd_hs) tag_mem[wptr_q] <= gnt;
  end

endmodule

// File: tb/tb_bp_me_cce_mem_arbiter.sv
// Scenario bench for bp_me_cce_mem_arbiter (2 requesters, 4-deep tags).
// Expected grants/owners are queued up front and popped as the DUT acts.
module tb_bp_me_cce_mem_arbiter;

  localparam int N  = 2;
  localparam int MW = 128;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [N*MW-1:0] mem_cmd_i;
  logic [N-1:0]    mem_cmd_v_i;
  logic [N-1:0]    mem_cmd_ready_o;
  logic [MW-1:0]   mem_cmd_o;
  logic            mem_cmd_v_o;
  logic            mem_cmd_ready_i;
  logic [MW-1:0]   mem_resp_i;
  logic            mem_resp_v_i;
  logic            mem_resp_yumi_o;
  logic [MW-1:0]   mem_resp_o;
  logic [N-1:0]    mem_resp_v_o;
  logic [N-1:0]    mem_resp_yumi_i;
  logic            err_o;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  int own_q[$];
  logic [MW-1:0] rdat;

  always #5 clk_i = ~clk_i;

  bp_me_cce_mem_arbiter #(
    .num_req_p(N), .msg_width_p(MW),
    .tag_els_p(4), .max_out_p(2)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i),
    .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o),
    .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i),
    .mem_resp_yumi_o(mem_resp_yumi_o),
    .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o),
    .mem_resp_yumi_i(mem_resp_yumi_i), .err_o(err_o)
  );

  function automatic logic [MW-1:0] cw(input int k, input int n);
    return {32'hC0DE0000 + 32'(k), 64'h0, 32'(n)};
  endfunction

  task automatic set_cmd(input int n);
    for (int k = 0; k < N; k++) mem_cmd_i[k*MW +: MW] = cw(k, n);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in;
    mem_cmd_v_i     = '0;
    mem_cmd_ready_i = 1'b0;
    mem_resp_v_i    = 1'b0;
    mem_resp_yumi_i = '0;
    mem_resp_i      = '0;
    set_cmd(0);
  endtask

  task automatic do_reset;
    exp_q.delete();
    own_q.delete();
    idle_in();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset;
    idle_in();
    reset_i         = 1'b1;
    mem_cmd_v_i     = 2'b11;
    mem_cmd_ready_i = 1'b1;
    mem_resp_v_i    = 1'b1;
    mem_resp_yumi_i = 2'b11;
    @(negedge clk_i);
    n_chk++;
    if (mem_cmd_v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cmd_v got %b want 0", mem_cmd_v_o);
    end
    n_chk++;
    if (mem_cmd_ready_o !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_ready got %b want 00", mem_cmd_ready_o);
    end
    n_chk++;
    if (mem_resp_v_o !== 2'b00 || mem_resp_yumi_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_resp got v=%b y=%b want 00/0",
               mem_resp_v_o, mem_resp_yumi_o);
    end
    tick();
    idle_in();
    reset_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (err_o !== 1'b0 || mem_cmd_v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst got err=%b v=%b want 0/0",
               err_o, mem_cmd_v_o);
    end
    tick();
  endtask

  task automatic test_alternate;
    logic [1:0] e;
    int g, o;
    do_reset();
    exp_q = '{0, 1, 0, 1};
    rdat  = {4{32'h5EED_0000}};
    for (int c = 0; c < 5; c++) begin
      mem_cmd_v_i     = (c < 4) ? 2'b11 : 2'b00;
      mem_cmd_ready_i = 1'b1;
      set_cmd(c);
      mem_resp_i      = rdat + MW'(c);
      mem_resp_v_i    = (own_q.size() > 0);
      mem_resp_yumi_i = (own_q.size() > 0)
                      ? (2'b01 << own_q[0]) : 2'b00;
      @(negedge clk_i);
      if (own_q.size() > 0) begin
        o = own_q.pop_front();
        e = 2'b01 << o;
        n_chk++;
        if (mem_resp_v_o !== e || mem_resp_yumi_o !== 1'b1) begin
          n_fail++;
          $display("FAIL alt_resp%0d got v=%b y=%b want %b/1",
                   c, mem_resp_v_o, mem_resp_yumi_o, e);
        end
        n_chk++;
        if (mem_resp_o !== rdat + MW'(c)) begin
          n_fail++;
          $display("FAIL alt_rdata%0d got %h want %h",
                   c, mem_resp_o, rdat + MW'(c));
        end
      end
      if (c < 4) begin
        g = exp_q.pop_front();
        e = 2'b01 << g;
        n_chk++;
        if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== cw(g, c) ||
            mem_cmd_ready_o !== e) begin
          n_fail++;
          $display("FAIL alt_gnt%0d got v=%b d=%h r=%b want g=%0d",
                   c, mem_cmd_v_o, mem_cmd_o, mem_cmd_ready_o, g);
        end
        own_q.push_back(g);
      end
      tick();
    end
  endtask

  task automatic test_locked;
    logic [1:0] vt [5];
    logic       rt [5];
    logic [1:0] e;
    int g, o;
    do_reset();
    vt    = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
    rt    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_q = '{1, 1, 1, 1, 0};
    for (int c = 0; c < 5; c++) begin
      mem_cmd_v_i     = vt[c];
      mem_cmd_ready_i = rt[c];
      set_cmd(c);
      @(negedge clk_i);
      g = exp_q.pop_front();
      e = rt[c] ? (2'b01 << g) : 2'b00;
      n_chk++;
      if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== cw(g, c) ||
          mem_cmd_ready_o !== e) begin
        n_fail++;
        $display("FAIL lock_gnt%0d got v=%b d=%h r=%b want g=%0d r=%b",
                 c, mem_cmd_v_o, mem_cmd_o, mem_cmd_ready_o, g, e);
      end
      if (rt[c]) own_q.push_back(g);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      idle_in();
      mem_resp_v_i    = 1'b1;
      mem_resp_yumi_i = 2'b01 << own_q[0];
      @(negedge clk_i);
      o = own_q.pop_front();
      e = 2'b01 << o;
      n_chk++;
      if (mem_resp_v_o !== e || mem_resp_yumi_o !== 1'b1) begin
        n_fail++;
        $display("FAIL lock_resp%0d got v=%b y=%b want %b/1",
                 c, mem_resp_v_o, mem_resp_yumi_o, e);
      end
      tick();
    end
    idle_in();
  endtask

  task automatic test_fifo_full;
    logic [1:0] e;
    int o;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      mem_cmd_v_i     = 2'b01;
      mem_cmd_ready_i = 1'b1;
      set_cmd(c);
      mem_resp_v_i    = (c == 6);
      mem_resp_yumi_i = (c == 6) ? 2'b01 : 2'b00;
      @(negedge clk_i);
      if (c < 4 || c == 7) begin
        n_chk++;
        if (mem_cmd_v_o !== 1'b1 || mem_cmd_ready_o !== 2'b01 ||
            mem_cmd_o !== cw(0, c)) begin
          n_fail++;
          $display("FAIL full_issue%0d got v=%b r=%b want 1/01",
                   c, mem_cmd_v_o, mem_cmd_ready_o);
        end
        own_q.push_back(0);
      end else begin
        n_chk++;
        if (mem_cmd_v_o !== 1'b0 || mem_cmd_ready_o !== 2'b00) begin
          n_fail++;
          $display("FAIL full_block%0d got v=%b r=%b want 0/00",
                   c, mem_cmd_v_o, mem_cmd_ready_o);
        end
      end
      if (c == 6) begin
        o = own_q.pop_front();
        n_chk++;
        if (mem_resp_v_o !== (2'b01 << o) || mem_resp_yumi_o !== 1'b1) begin
          n_fail++;
          $display("FAIL full_deq got v=%b y=%b want 01/1",
                   mem_resp_v_o, mem_resp_yumi_o);
        end
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      idle_in();
      mem_resp_v_i    = 1'b1;
      mem_resp_yumi_i = 2'b01 << own_q[0];
      @(negedge clk_i);
      o = own_q.pop_front();
      e = 2'b01 << o;
      n_chk++;
      if (mem_resp_v_o !== e || mem_resp_yumi_o !== 1'b1) begin
        n_fail++;
        $display("FAIL full_drain%0d got v=%b y=%b want %b/1",
                 c, mem_resp_v_o, mem_resp_yumi_o, e);
      end
      tick();
    end
    idle_in();
    @(negedge clk_i);
    n_chk++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_noerr got err=%b want 0", err_o);
    end
    tick();
  endtask

  task automatic test_err_empty;
    do_reset();
    mem_resp_v_i = 1'b1;
    @(negedge clk_i);
    n_chk++;
    if (mem_resp_v_o !== 2'b00 || mem_resp_yumi_o !== 1'b0 ||
        err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_resp got v=%b y=%b e=%b want 00/0/0",
               mem_resp_v_o, mem_resp_yumi_o, err_o);
    end
    tick();
    idle_in();
    @(negedge clk_i);
    n_chk++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_err got %b want 1", err_o);
    end
    tick();
    tick();
    tick();
    @(negedge clk_i);
    n_chk++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_sticky got %b want 1", err_o);
    end
    tick();
  endtask

  task automatic test_err_yumi;
    do_reset();
    mem_cmd_v_i     = 2'b01;
    mem_cmd_ready_i = 1'b1;
    tick();
    idle_in();
    mem_resp_v_i    = 1'b1;
    mem_resp_yumi_i = 2'b10;
    @(negedge clk_i);
    n_chk++;
    if (mem_resp_v_o !== 2'b01 || mem_resp_yumi_o !== 1'b0 ||
        err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_yumi got v=%b y=%b e=%b want 01/0/0",
               mem_resp_v_o, mem_resp_yumi_o, err_o);
    end
    tick();
    mem_resp_yumi_i = 2'b01;
    @(negedge clk_i);
    n_chk++;
    if (err_o !== 1'b1 || mem_resp_yumi_o !== 1'b1 ||
        mem_resp_v_o !== 2'b01) begin
      n_fail++;
      $display("FAIL bad_yumi_after got e=%b y=%b v=%b want 1/1/01",
               err_o, mem_resp_yumi_o, mem_resp_v_o);
    end
    tick();
    idle_in();
  endtask

  task automatic test_reset_mid;
    do_reset();
    mem_cmd_ready_i = 1'b1;
    mem_cmd_v_i     = 2'b01;
    tick();
    tick();
    mem_cmd_ready_i = 1'b0;
    mem_cmd_v_i     = 2'b10;
    set_cmd(7);
    @(negedge clk_i);
    n_chk++;
    if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== cw(1, 7)) begin
      n_fail++;
      $display("FAIL mid_lock got v=%b d=%h want 1/%h",
               mem_cmd_v_o, mem_cmd_o, cw(1, 7));
    end
    tick();
    reset_i = 1'b1;
    @(negedge clk_i);
    n_chk++;
    if (mem_cmd_v_o !== 1'b0 || mem_cmd_ready_o !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_in_rst got v=%b r=%b want 0/00",
               mem_cmd_v_o, mem_cmd_ready_o);
    end
    tick();
    reset_i      = 1'b0;
    idle_in();
    mem_resp_v_i = 1'b1;
    @(negedge clk_i);
    n_chk++;
    if (mem_cmd_v_o !== 1'b0 || mem_resp_v_o !== 2'b00 ||
        mem_resp_yumi_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after got v=%b rv=%b y=%b want 0/00/0",
               mem_cmd_v_o, mem_resp_v_o, mem_resp_yumi_o);
    end
    tick();
    idle_in();
    mem_cmd_v_i     = 2'b11;
    mem_cmd_ready_i = 1'b1;
    set_cmd(9);
    @(negedge clk_i);
    n_chk++;
    if (err_o !== 1'b1 || mem_cmd_ready_o !== 2'b01 ||
        mem_cmd_o !== cw(0, 9)) begin
      n_fail++;
      $display("FAIL mid_rr got e=%b r=%b want 1/01",
               err_o, mem_cmd_ready_o);
    end
    tick();
    idle_in();
  endtask

`ifdef BP_ME_MEM_ARB_CREDIT_EN
  task automatic test_credit;
    logic [1:0] vt [6];
    logic       ev [6];
    int o;
    do_reset();
    vt    = '{2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01};
    ev    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_q = '{0, 0, 1, 0};
    for (int c = 0; c < 6; c++) begin
      mem_cmd_v_i     = vt[c];
      mem_cmd_ready_i = 1'b1;
      mem_resp_v_i    = (c == 4);
      mem_resp_yumi_i = (c == 4) ? 2'b01 : 2'b00;
      @(negedge clk_i);
      n_chk++;
      if (mem_cmd_v_o !== ev[c]) begin
        n_fail++;
        $display("FAIL cr_v%0d got %b want %b", c, mem_cmd_v_o, ev[c]);
      end
      if (ev[c]) begin
        o = exp_q.pop_front();
        n_chk++;
        if (mem_cmd_ready_o !== (2'b01 << o)) begin
          n_fail++;
          $display("FAIL cr_gnt%0d got %b want g=%0d",
                   c, mem_cmd_ready_o, o);
        end
      end
      if (c == 4) begin
        n_chk++;
        if (mem_resp_yumi_o !== 1'b1) begin
          n_fail++;
          $display("FAIL cr_yumi got %b want 1", mem_resp_yumi_o);
        end
      end
      tick();
    end
    idle_in();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1'b1;
    idle_in();
    tick();
    test_reset();
    test_alternate();
    test_locked();
    test_fifo_full();
    test_err_empty();
    test_err_yumi();
    test_reset_mid();
`ifdef BP_ME_MEM_ARB_CREDIT_EN
    test_credit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
